// File: rtl/cv32e40x_xif_pkg.sv
// X-IF memory channel types shared by the coprocessor and the CPU-side responder.
// Only the fields the memory responder exchanges are carried.
package cv32e40x_xif_pkg;

    localparam int unsigned XIF_ID_WIDTH  = 4;
    localparam int unsigned XIF_MEM_WIDTH = 32;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0]    id;
        logic [31:0]                addr;
        logic                       we;
        logic [2:0]                 size;
        logic [XIF_MEM_WIDTH/8-1:0] be;
        logic [XIF_MEM_WIDTH-1:0]   wdata;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
    } x_mem_resp_t;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0]  id;
        logic [XIF_MEM_WIDTH-1:0] rdata;
        logic                     err;
    } x_mem_result_t;

endpackage

// File: rtl/xif_mem_resp_pkg.sv
// Shared state encoding and RISC-V exception codes for the X-IF memory responder.
package xif_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2,
        RESULT   = 2'd3
    } state_e;

    localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
    localparam logic [5:0] EXC_LD_FAULT    = 6'd5;
    localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;
    localparam logic [5:0] EXC_ST_FAULT    = 6'd7;

endpackage

// File: rtl/xif_mem_responder.sv
// CPU-side X-IF memory responder: checks coprocessor memory requests for legality and
// turns legal ones into single OBI word transactions, returning a tagged result pulse.
module xif_mem_responder
    import cv32e40x_xif_pkg::*;
    import xif_mem_resp_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = XIF_ID_WIDTH,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0001_0000
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          xif_mem_valid_i,
    output logic          xif_mem_ready_o,
    input  x_mem_req_t    xif_mem_req_i,
    output x_mem_resp_t   xif_mem_resp_o,
    output logic          xif_mem_result_valid_o,
    output x_mem_result_t xif_mem_result_o,

    output logic          data_req_o,
    input  logic          data_gnt_i,
    output logic [31:0]   data_addr_o,
    output logic          data_we_o,
    output logic [3:0]    data_be_o,
    output logic [31:0]   data_wdata_o,
    input  logic          data_rvalid_i,
    input  logic [31:0]   data_rdata_i,
    input  logic          data_err_i
);

    state_e state_q, state_d;

    logic        handshake;
    logic        accept;
    logic [31:0] offset;
    logic        in_window;
    logic        misaligned;
    x_mem_resp_t check;

    logic [X_ID_WIDTH-1:0] id_p1;
    logic [29:0]           word_addr_p1;
    logic                  we_p1;
    logic [3:0]            be_p1;
    logic [31:0]           wdata_p1;
    logic [31:0]           rdata_p2;
    logic                  err_p2;

    // Offset compare handles the window without a constant lower-bound comparison.
    always_comb begin
        offset     = xif_mem_req_i.addr - MEM_BASE;
        in_window  = (offset < MEM_SIZE);
        misaligned = ((xif_mem_req_i.size == 3'd2) && (xif_mem_req_i.addr[1:0] != 2'b00)) ||
                     ((xif_mem_req_i.size == 3'd1) && xif_mem_req_i.addr[0]);
        check      = '0;
        if (!in_window) begin
            check.exc     = 1'b1;
            check.exccode = xif_mem_req_i.we ? EXC_ST_FAULT : EXC_LD_FAULT;
        end else if (misaligned) begin
            check.exc     = 1'b1;
            check.exccode = xif_mem_req_i.we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
        end
    end

    assign handshake      = xif_mem_valid_i && xif_mem_ready_o;
    assign accept         = handshake && !check.exc;
    assign xif_mem_resp_o = handshake ? check : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept)        state_d = BUS_REQ;
            BUS_REQ:  if (data_gnt_i)    state_d = BUS_WAIT;
            BUS_WAIT: if (data_rvalid_i) state_d = RESULT;
            RESULT:                      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        xif_mem_ready_o        = (state_q == IDLE);
        data_req_o             = (state_q == BUS_REQ);
        xif_mem_result_valid_o = (state_q == RESULT);
    end

    // Stage 1: request fields captured at the accepting handshake, held through the bus access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_p1        <= '0;
            word_addr_p1 <= '0;
            we_p1        <= 1'b0;
            be_p1        <= '0;
            wdata_p1     <= '0;
        end else if (accept) begin
            id_p1        <= X_ID_WIDTH'(xif_mem_req_i.id);
            word_addr_p1 <= xif_mem_req_i.addr[31:2];
            we_p1        <= xif_mem_req_i.we;
            be_p1        <= xif_mem_req_i.be;
            wdata_p1     <= xif_mem_req_i.wdata;
        end
    end

    // Stage 2: bus response captured; writes report zero read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_p2 <= '0;
            err_p2   <= 1'b0;
        end else if ((state_q == BUS_WAIT) && data_rvalid_i) begin
            rdata_p2 <= we_p1 ? 32'h0 : data_rdata_i;
            err_p2   <= data_err_i;
        end
    end

    assign data_addr_o  = {word_addr_p1, 2'b00};
    assign data_we_o    = we_p1;
    assign data_be_o    = be_p1;
    assign data_wdata_o = wdata_p1;

    assign xif_mem_result_o.id    = XIF_ID_WIDTH'(id_p1);
    assign xif_mem_result_o.rdata = rdata_p2;
    assign xif_mem_result_o.err   = err_p2;

endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed and randomized bench for xif_mem_responder with a word-memory bus model.
module tb_xif_mem_responder;
    import cv32e40x_xif_pkg::*;

    localparam logic [31:0] MEM_BASE = 32'h0000_0000;
    localparam logic [31:0] MEM_SIZE = 32'h0001_0000;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          xif_mem_valid_i = 1'b0;
    logic          xif_mem_ready_o;
    x_mem_req_t    xif_mem_req_i = '0;
    x_mem_resp_t   xif_mem_resp_o;
    logic          xif_mem_result_valid_o;
    x_mem_result_t xif_mem_result_o;
    logic          data_req_o;
    logic          data_gnt_i = 1'b0;
    logic [31:0]   data_addr_o;
    logic          data_we_o;
    logic [3:0]    data_be_o;
    logic [31:0]   data_wdata_o;
    logic          data_rvalid_i = 1'b0;
    logic [31:0]   data_rdata_i = '0;
    logic          data_err_i = 1'b0;

    xif_mem_responder #(
        .X_ID_WIDTH (4),
        .MEM_BASE   (MEM_BASE),
        .MEM_SIZE   (MEM_SIZE)
    ) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .xif_mem_valid_i        (xif_mem_valid_i),
        .xif_mem_ready_o        (xif_mem_ready_o),
        .xif_mem_req_i          (xif_mem_req_i),
        .xif_mem_resp_o         (xif_mem_resp_o),
        .xif_mem_result_valid_o (xif_mem_result_valid_o),
        .xif_mem_result_o       (xif_mem_result_o),
        .data_req_o             (data_req_o),
        .data_gnt_i             (data_gnt_i),
        .data_addr_o            (data_addr_o),
        .data_we_o              (data_we_o),
        .data_be_o              (data_be_o),
        .data_wdata_o           (data_wdata_o),
        .data_rvalid_i          (data_rvalid_i),
        .data_rdata_i           (data_rdata_i),
        .data_err_i             (data_err_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [int unsigned];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {exc, exccode} as the architecture defines it: window first, then alignment.
    function automatic logic [6:0] exp_resp(input logic [31:0] a, input logic we, input logic [2:0] sz);
        longint unsigned av = a;
        longint unsigned lo = MEM_BASE;
        longint unsigned hi = longint'(MEM_BASE) + longint'(MEM_SIZE);
        if (av < lo || av >= hi) return {1'b1, we ? 6'd7 : 6'd5};
        if ((sz == 3'd2 && a[1:0] != 2'b00) || (sz == 3'd1 && a[0])) return {1'b1, we ? 6'd6 : 6'd4};
        return 7'd0;
    endfunction

    function automatic logic [31:0] mem_rd(input int unsigned wi);
        return mem.exists(wi) ? mem[wi] : 32'h0;
    endfunction

    task automatic drive_hs(input logic [3:0] id, input logic [31:0] a, input logic we,
                            input logic [2:0] sz, input logic [3:0] be, input logic [31:0] wd,
                            output logic [6:0] er);
        er = exp_resp(a, we, sz);
        @(negedge clk_i);
        xif_mem_valid_i     = 1'b1;
        xif_mem_req_i.id    = id;
        xif_mem_req_i.addr  = a;
        xif_mem_req_i.we    = we;
        xif_mem_req_i.size  = sz;
        xif_mem_req_i.be    = be;
        xif_mem_req_i.wdata = wd;
        #1;
        chk("hs_ready", xif_mem_ready_o, 1);
        chk("hs_no_result", xif_mem_result_valid_o, 0);
        chk("hs_resp", {xif_mem_resp_o.exc, xif_mem_resp_o.exccode}, er);
        @(negedge clk_i);
        xif_mem_valid_i = 1'b0;
        xif_mem_req_i   = x_mem_req_t'({$urandom, $urandom, $urandom});
        #1;
        chk("resp_outside_hs", {xif_mem_resp_o.exc, xif_mem_resp_o.exccode}, 0);
    endtask

    // One full transaction; ends one step into the RESULT cycle so the next may follow back-to-back.
    task automatic run_txn(input logic [3:0] id, input logic [31:0] a, input logic we,
                           input logic [2:0] sz, input logic [3:0] be, input logic [31:0] wd,
                           input int gdly, input logic berr);
        logic [6:0]  er;
        logic [31:0] word;
        logic [31:0] nw;
        int unsigned wi;
        wi = a[31:2];
        drive_hs(id, a, we, sz, be, wd, er);
        if (er[6]) begin
            for (int k = 0; k < 3; k++) begin
                chk("exc_no_req", data_req_o, 0);
                chk("exc_no_result", xif_mem_result_valid_o, 0);
                chk("exc_ready", xif_mem_ready_o, 1);
                @(negedge clk_i); #1;
            end
            return;
        end
        for (int k = 0; k <= gdly; k++) begin
            chk("bus_req", data_req_o, 1);
            chk("bus_addr", data_addr_o, {a[31:2], 2'b00});
            chk("bus_we", data_we_o, we);
            chk("bus_be", data_be_o, be);
            if (we) chk("bus_wdata", data_wdata_o, wd);
            chk("busy_ready", xif_mem_ready_o, 0);
            chk("no_early_result", xif_mem_result_valid_o, 0);
            data_gnt_i = (k == gdly);
            @(negedge clk_i); #1;
        end
        data_gnt_i = 1'b0;
        chk("req_dropped", data_req_o, 0);
        chk("wait_ready", xif_mem_ready_o, 0);
        chk("wait_no_result", xif_mem_result_valid_o, 0);
        word          = mem_rd(wi);
        data_rvalid_i = 1'b1;
        data_err_i    = berr;
        data_rdata_i  = we ? $urandom : word;
        @(negedge clk_i); #1;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = $urandom;
        chk("result_valid", xif_mem_result_valid_o, 1);
        chk("result_id", xif_mem_result_o.id, id);
        chk("result_rdata", xif_mem_result_o.rdata, we ? 32'h0 : word);
        chk("result_err", xif_mem_result_o.err, berr);
        chk("result_ready", xif_mem_ready_o, 0);
        if (we && !berr) begin
            nw = word;
            for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
            mem[wi] = nw;
        end
    endtask

    initial begin
        logic [6:0]  er;
        logic [31:0] ra;
        logic [2:0]  rs;
        int          sel;

        #1;
        chk("rst_ready", xif_mem_ready_o, 1);
        chk("rst_result_valid", xif_mem_result_valid_o, 0);
        chk("rst_data_req", data_req_o, 0);
        chk("rst_data_addr", data_addr_o, 0);
        chk("rst_data_we_be", {data_we_o, data_be_o}, 0);
        chk("rst_data_wdata", data_wdata_o, 0);
        chk("rst_result", xif_mem_result_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        run_txn(4'd1, 32'h100, 1'b1, 3'd2, 4'hF, 32'hDEADBEEF, 0, 1'b0);
        run_txn(4'd3, 32'h100, 1'b0, 3'd2, 4'hF, 32'h0, 0, 1'b0);
        run_txn(4'd5, 32'h100, 1'b0, 3'd2, 4'hF, 32'h0, 5, 1'b0);
        @(negedge clk_i); #1;
        chk("stall_single_pulse", xif_mem_result_valid_o, 0);
        run_txn(4'd6, 32'h0002_0000, 1'b0, 3'd2, 4'hF, 32'h0, 0, 1'b0);
        run_txn(4'd7, 32'h102, 1'b1, 3'd2, 4'hF, 32'h12345678, 0, 1'b0);
        run_txn(4'd8, 32'h102, 1'b0, 3'd1, 4'hC, 32'h0, 0, 1'b0);
        run_txn(4'd9, 32'h104, 1'b0, 3'd2, 4'hF, 32'h0, 1, 1'b1);

        // Reset while waiting for the bus response; the stray rvalid afterwards must be ignored.
        drive_hs(4'd2, 32'h100, 1'b0, 3'd2, 4'hF, 32'h0, er);
        data_gnt_i = 1'b1;
        @(negedge clk_i); #1;
        data_gnt_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("midrst_req", data_req_o, 0);
        chk("midrst_ready", xif_mem_ready_o, 1);
        chk("midrst_result_valid", xif_mem_result_valid_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hBAD0BAD0;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stray_no_result", xif_mem_result_valid_o, 0);
            chk("stray_ready", xif_mem_ready_o, 1);
            chk("stray_no_req", data_req_o, 0);
            @(negedge clk_i);
        end
        run_txn(4'd4, 32'h100, 1'b0, 3'd2, 4'hF, 32'h0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0) ra = 32'h0001_0000 + $urandom_range(0, 32'hFFFF);
            else if (sel == 1) ra = 32'hFFFF_FFFC;
            else ra = 32'h100 + $urandom_range(0, 31);
            rs = 3'($urandom_range(0, 2));
            run_txn(4'($urandom), ra, 1'($urandom), rs, 4'($urandom), $urandom,
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
